// File: rtl/slave_in_port_if.sv
// rtl/slave_in_port_if.sv - serial slave request/response bus and local memory port bundle
// Purpose: groups every non-clock signal of slave_in_port.
// Ports (slave view): master_valid/read_en/write_en request qualifiers,
// tx_address/tx_data/tx_burst serial inputs (LSB first), slave_ready,
// rx_data/rx_valid serial read return, mem_addr/mem_wdata/mem_wr_en/
// mem_rd_en memory command side, mem_rdata memory return.
interface slave_in_port_if #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 8
);
    logic                  master_valid;
    logic                  read_en;
    logic                  write_en;
    logic                  tx_address;
    logic                  tx_data;
    logic                  tx_burst;
    logic                  slave_ready;
    logic                  rx_data;
    logic                  rx_valid;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic                  mem_wr_en;
    logic                  mem_rd_en;
    logic [DATA_WIDTH-1:0] mem_rdata;

    modport slave (
        input  master_valid, read_en, write_en,
        input  tx_address, tx_data, tx_burst,
        input  mem_rdata,
        output slave_ready, rx_data, rx_valid,
        output mem_addr, mem_wdata, mem_wr_en, mem_rd_en
    );

    modport master (
        output master_valid, read_en, write_en,
        output tx_address, tx_data, tx_burst,
        output mem_rdata,
        input  slave_ready, rx_data, rx_valid,
        input  mem_addr, mem_wdata, mem_wr_en, mem_rd_en
    );
endinterface

// File: rtl/slave_in_port.sv
// rtl/slave_in_port.sv - serial-in slave port bridging bit-serial bursts to a local memory
// Purpose: accepts a read or write request, shifts in a serial address and
// burst length, then either shifts in write beats and strobes them into
// memory, or reads memory beat by beat and shifts the words back out.
// Ports: clk (rising edge), rst (synchronous, active high),
// bus (slave_in_port_if.slave: request/serial lines, memory port).
module slave_in_port #(
    parameter int ADDR_WIDTH  = 12,
    parameter int DATA_WIDTH  = 8,
    parameter int BURST_WIDTH = 4
) (
    input  logic           clk,
    input  logic           rst,
    slave_in_port_if.slave bus
);

    localparam int CNT_MAX = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
    localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        WDATA,
        RREQ,
        RWAIT,
        RDATA
    } state_t;

    state_t                 state_q, state_d;
    logic [CW-1:0]          bit_cnt_q, bit_cnt_d;
    logic [BURST_WIDTH-1:0] burst_q, burst_d;
    logic [BURST_WIDTH-1:0] beat_cnt_q, beat_cnt_d;
    logic [ADDR_WIDTH-1:0]  addr_sr_q, addr_sr_d;
    logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic [ADDR_WIDTH-1:0]  mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0]  wsr_q, wsr_d;
    logic [DATA_WIDTH-1:0]  rsr_q, rsr_d;
    logic [DATA_WIDTH-1:0]  mem_wdata_q, mem_wdata_d;
    logic                   is_write_q, is_write_d;
    logic                   wr_en_q, wr_en_d;

    logic                   accept;
    logic                   abort;
    logic                   last_addr_bit;
    logic                   last_data_bit;
    logic                   last_beat;
    logic                   rx_valid_w;

    always_comb begin
        accept        = bus.master_valid && (bus.read_en ^ bus.write_en);
        abort         = (state_q != IDLE) && !bus.master_valid;
        last_addr_bit = (int'(bit_cnt_q) == ADDR_WIDTH - 1);
        last_data_bit = (int'(bit_cnt_q) == DATA_WIDTH - 1);
        last_beat     = (beat_cnt_q == burst_q);
    end

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        burst_d     = burst_q;
        beat_cnt_d  = beat_cnt_q;
        addr_sr_d   = addr_sr_q;
        addr_d      = addr_q;
        mem_addr_d  = mem_addr_q;
        wsr_d       = wsr_q;
        rsr_d       = rsr_q;
        mem_wdata_d = mem_wdata_q;
        is_write_d  = is_write_q;
        wr_en_d     = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d    = ADDR;
                    is_write_d = bus.write_en;
                    bit_cnt_d  = '0;
                    beat_cnt_d = '0;
                end
            end

            ADDR: begin
                // Both fields shift in from the top so bit 0 ends up holding the first sample.
                addr_sr_d = {bus.tx_address, addr_sr_q[ADDR_WIDTH-1:1]};
                if (int'(bit_cnt_q) < BURST_WIDTH) begin
                    burst_d = {bus.tx_burst, burst_q[BURST_WIDTH-1:1]};
                end
                if (last_addr_bit) begin
                    bit_cnt_d = '0;
                    addr_d    = addr_sr_d;
                    if (is_write_q) begin
                        state_d = WDATA;
                    end else begin
                        state_d    = RREQ;
                        mem_addr_d = addr_sr_d;
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q + CW'(1);
                end
            end

            WDATA: begin
                wsr_d = {bus.tx_data, wsr_q[DATA_WIDTH-1:1]};
                if (last_data_bit) begin
                    // Strobe lands in the next cycle, overlapping bit 0 of the following beat.
                    bit_cnt_d   = '0;
                    wr_en_d     = 1'b1;
                    mem_addr_d  = addr_q;
                    mem_wdata_d = wsr_d;
                    addr_d      = addr_q + ADDR_WIDTH'(1);
                    beat_cnt_d  = beat_cnt_q + BURST_WIDTH'(1);
                    if (last_beat) begin
                        state_d = IDLE;
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q + CW'(1);
                end
            end

            RREQ: begin
                // mem_addr already holds this beat's address; advance the running one.
                addr_d  = addr_q + ADDR_WIDTH'(1);
                state_d = RWAIT;
            end

            RWAIT: begin
                rsr_d     = bus.mem_rdata;
                bit_cnt_d = '0;
                state_d   = RDATA;
            end

            RDATA: begin
                rsr_d = rsr_q >> 1;
                if (last_data_bit) begin
                    bit_cnt_d = '0;
                    if (last_beat) begin
                        state_d = IDLE;
                    end else begin
                        state_d    = RREQ;
                        mem_addr_d = addr_q;
                        beat_cnt_d = beat_cnt_q + BURST_WIDTH'(1);
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q + CW'(1);
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        // A withdrawn request wins over everything: an unfinished beat is dropped
        // and the memory-facing registers keep whatever they last showed.
        if (abort) begin
            state_d     = IDLE;
            wr_en_d     = 1'b0;
            mem_addr_d  = mem_addr_q;
            mem_wdata_d = mem_wdata_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            burst_q     <= '0;
            beat_cnt_q  <= '0;
            addr_sr_q   <= '0;
            addr_q      <= '0;
            mem_addr_q  <= '0;
            wsr_q       <= '0;
            rsr_q       <= '0;
            mem_wdata_q <= '0;
            is_write_q  <= 1'b0;
            wr_en_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            burst_q     <= burst_d;
            beat_cnt_q  <= beat_cnt_d;
            addr_sr_q   <= addr_sr_d;
            addr_q      <= addr_d;
            mem_addr_q  <= mem_addr_d;
            wsr_q       <= wsr_d;
            rsr_q       <= rsr_d;
            mem_wdata_q <= mem_wdata_d;
            is_write_q  <= is_write_d;
            wr_en_q     <= wr_en_d;
        end
    end

    // Strobes are masked while rst is high so a reset landing mid-transaction
    // never lets a stale registered strobe reach memory.
    assign rx_valid_w      = (state_q == RDATA) && bus.master_valid && !rst;
    assign bus.rx_valid    = rx_valid_w;
    assign bus.rx_data     = rx_valid_w && rsr_q[0];
    assign bus.slave_ready = (state_q == IDLE);
    assign bus.mem_wr_en   = wr_en_q && !rst;
    assign bus.mem_rd_en   = (state_q == RREQ) && !rst;
    assign bus.mem_addr    = mem_addr_q;
    assign bus.mem_wdata   = mem_wdata_q;

endmodule

// File: tb/tb_slave_in_port.sv
// tb/tb_slave_in_port.sv - randomized self-checking bench for slave_in_port
module tb_slave_in_port;
    localparam int AW   = 12;
    localparam int DW   = 8;
    localparam int BW   = 4;
    localparam int MAXC = 200;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    slave_in_port_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    slave_in_port #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BURST_WIDTH(BW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cur_t = 0;

    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic [DW-1:0] words [0:15];

    bit            e_rdy [MAXC];
    bit            e_wr  [MAXC];
    bit            e_rd  [MAXC];
    bit            e_rxv [MAXC];
    bit            e_rxd [MAXC];
    logic [AW-1:0] e_sa  [MAXC];
    logic [DW-1:0] e_sd  [MAXC];
    bit            s_mv  [MAXC];
    bit            s_ab  [MAXC];
    bit            s_db  [MAXC];
    bit            s_bb  [MAXC];
    bit            s_rst [MAXC];
    logic [DW-1:0] s_rdata [MAXC];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s t=%0d: got %0h expected %0h", tag, cur_t, got, exp);
        end
    endtask

    task automatic check_outputs(input bit rdy, input bit wr, input bit rd,
                                 input bit rxv, input bit rxd);
        chk("slave_ready", bus.slave_ready, rdy);
        chk("mem_wr_en",   bus.mem_wr_en,   wr);
        chk("mem_rd_en",   bus.mem_rd_en,   rd);
        chk("rx_valid",    bus.rx_valid,    rxv);
        chk("rx_data",     bus.rx_data,     rxd);
        chk("mem_addr",    bus.mem_addr,    m_addr);
        chk("mem_wdata",   bus.mem_wdata,   m_wdata);
    endtask

    // Idle-state cycles; requests with read_en == write_en must be ignored.
    task automatic idle_cycles(input int n, input bit force_both);
        for (int i = 0; i < n; i++) begin
            logic en;
            @(posedge clk);
            #1;
            cur_t          = -1;
            rst            = 1'b0;
            en             = 1'($urandom);
            bus.master_valid = force_both ? 1'b1 : 1'($urandom);
            bus.read_en    = force_both ? 1'b1 : en;
            bus.write_en   = force_both ? 1'b1 : en;
            bus.tx_address = 1'($urandom);
            bus.tx_data    = 1'($urandom);
            bus.tx_burst   = 1'($urandom);
            bus.mem_rdata  = DW'($urandom);
            @(negedge clk);
            check_outputs(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        end
    endtask

    // One transaction from the acceptance cycle T0, with expectations derived
    // from the cycle schedule of the protocol; optional abort or reset cycle.
    task automatic run_txn(input bit is_wr, input int a, input int burst,
                           input int abort_at, input int rst_at);
        int fin;
        int len;
        int t;
        fin = is_wr ? (21 + 8 * burst) : (23 + 10 * burst);
        len = fin + 1;
        if (abort_at > 0) len = abort_at + 2;
        if (rst_at > 0)   len = rst_at + 2;

        for (int i = 0; i < MAXC; i++) begin
            e_rdy[i]   = (i == 0) || (i >= fin);
            e_wr[i]    = 1'b0;
            e_rd[i]    = 1'b0;
            e_rxv[i]   = 1'b0;
            e_rxd[i]   = 1'b0;
            e_sa[i]    = '0;
            e_sd[i]    = '0;
            s_mv[i]    = (i < fin);
            s_ab[i]    = 1'($urandom);
            s_db[i]    = 1'($urandom);
            s_bb[i]    = 1'($urandom);
            s_rst[i]   = 1'b0;
            s_rdata[i] = DW'($urandom);
        end
        for (int i = 0; i < AW; i++) s_ab[1 + i] = a[i];
        for (int i = 0; i < BW; i++) s_bb[1 + i] = burst[i];

        for (int b = 0; b <= burst; b++) begin
            if (is_wr) begin
                for (int j = 0; j < DW; j++) s_db[13 + 8 * b + j] = words[b][j];
                t = 21 + 8 * b;
                e_wr[t] = 1'b1;
                e_sa[t] = AW'((a + b) % (1 << AW));
                e_sd[t] = words[b];
            end else begin
                t = 13 + 10 * b;
                e_rd[t] = 1'b1;
                e_sa[t] = AW'((a + b) % (1 << AW));
                s_rdata[t + 1] = words[b];
                for (int j = 0; j < DW; j++) begin
                    e_rxv[t + 2 + j] = 1'b1;
                    e_rxd[t + 2 + j] = words[b][j];
                end
            end
        end

        if (abort_at > 0) begin
            e_rxv[abort_at] = 1'b0;
            e_rxd[abort_at] = 1'b0;
            for (int i = abort_at; i < MAXC; i++) s_mv[i] = 1'b0;
            for (int i = abort_at + 1; i < MAXC; i++) begin
                e_rdy[i] = 1'b1; e_wr[i] = 1'b0; e_rd[i] = 1'b0;
                e_rxv[i] = 1'b0; e_rxd[i] = 1'b0;
            end
        end
        if (rst_at > 0) begin
            s_rst[rst_at] = 1'b1;
            for (int i = rst_at + 1; i < MAXC; i++) begin
                s_mv[i]  = 1'b0;
                e_rdy[i] = 1'b1; e_wr[i] = 1'b0; e_rd[i] = 1'b0;
                e_rxv[i] = 1'b0; e_rxd[i] = 1'b0;
            end
        end

        for (int k = 0; k < len; k++) begin
            @(posedge clk);
            #1;
            cur_t            = k;
            rst              = s_rst[k];
            bus.master_valid = s_mv[k];
            if (k == 0) begin
                bus.read_en  = !is_wr;
                bus.write_en = is_wr;
            end else begin
                bus.read_en  = 1'($urandom);
                bus.write_en = 1'($urandom);
            end
            bus.tx_address = s_ab[k];
            bus.tx_data    = s_db[k];
            bus.tx_burst   = s_bb[k];
            bus.mem_rdata  = s_rdata[k];
            @(negedge clk);
            if (e_wr[k] || e_rd[k]) m_addr = e_sa[k];
            if (e_wr[k]) m_wdata = e_sd[k];
            if (rst_at > 0 && k > rst_at) begin
                m_addr  = '0;
                m_wdata = '0;
            end
            if (rst_at > 0 && k == rst_at) begin
                chk("rst_cycle_wr", bus.mem_wr_en, 1'b0);
                chk("rst_cycle_rd", bus.mem_rd_en, 1'b0);
            end else begin
                check_outputs(e_rdy[k], e_wr[k], e_rd[k], e_rxv[k], e_rxd[k]);
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        int a;
        int burst;
        int fin;
        int mode;
        bit is_wr;

        rst              = 1'b1;
        bus.master_valid = 1'b0;
        bus.read_en      = 1'b0;
        bus.write_en     = 1'b0;
        bus.tx_address   = 1'b0;
        bus.tx_data      = 1'b0;
        bus.tx_burst     = 1'b0;
        bus.mem_rdata    = '0;
        m_addr           = '0;
        m_wdata          = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_outputs(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

        // single write, burst 0
        words[0] = 8'h3C;
        run_txn(1'b1, 'h0A5, 0, 0, 0);
        idle_cycles(2, 1'b0);

        // two-beat read across the address wrap
        words[0] = 8'h81;
        words[1] = 8'h7E;
        run_txn(1'b0, 'hFFF, 1, 0, 0);
        idle_cycles(1, 1'b0);

        // three-beat write
        words[0] = 8'h11;
        words[1] = 8'h22;
        words[2] = 8'h33;
        run_txn(1'b1, int'($urandom_range(0, 4095)), 2, 0, 0);

        // both enables high must be ignored, then a normal request follows
        idle_cycles(3, 1'b1);
        words[0] = DW'($urandom);
        run_txn(1'b0, int'($urandom_range(0, 4095)), 0, 0, 0);

        // abort at bit 4 of the second beat of a 3-beat write
        for (int i = 0; i < 16; i++) words[i] = DW'($urandom);
        run_txn(1'b1, int'($urandom_range(0, 4095)), 2, 13 + 8 + 4, 0);
        idle_cycles(1, 1'b0);

        // reset during RDATA
        run_txn(1'b0, int'($urandom_range(0, 4095)), 0, 0, 17);
        idle_cycles(1, 1'b0);

        for (int it = 0; it < 30; it++) begin
            for (int i = 0; i < 16; i++) words[i] = DW'($urandom);
            is_wr = 1'($urandom);
            burst = int'($urandom_range(0, 3));
            a     = ($urandom_range(0, 3) == 0) ? int'(4095 - $urandom_range(0, 2))
                                                : int'($urandom_range(0, 4095));
            fin   = is_wr ? (21 + 8 * burst) : (23 + 10 * burst);
            mode  = int'($urandom_range(0, 9));
            if (mode < 6)
                run_txn(is_wr, a, burst, 0, 0);
            else if (mode < 8)
                run_txn(is_wr, a, burst, int'($urandom_range(1, fin - 1)), 0);
            else
                run_txn(is_wr, a, burst, 0, int'($urandom_range(1, fin - 1)));
            idle_cycles(int'($urandom_range(0, 3)), 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
